// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, destination-field placement and router-ID sizing.
// Imported by the network-interface injector and ejector blocks.
package noc_pkg;

   localparam int FLIT_DATA_WIDTH = 32;

   // The destination router ID always occupies the top bits of a flit.
   localparam int DEST_MSB = FLIT_DATA_WIDTH - 1;

   function automatic int router_id_bits(input int num_routers);
      return (num_routers > 1) ? $clog2(num_routers) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; shared by the NI injection and ejection paths.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int DATAW = 32,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [DATAW-1:0] wdata,
   output logic [DATAW-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [DATAW-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; the count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ni_injector.sv
// Network-interface injector: queues core flit requests and injects them into the
// router local port under credit-based flow control; self-addressed requests are dropped.
module ni_injector
   import noc_pkg::*;
#(
   parameter int NUM_VC      = 4,
   parameter int NUM_ROUTERS = 16,
   parameter int ROUTER_ID   = 0,
   parameter int FIFO_DEPTH  = 4,
   localparam int ROUTER_ID_BITS = router_id_bits(NUM_ROUTERS),
   localparam int PAYLOAD_W      = FLIT_DATA_WIDTH - ROUTER_ID_BITS,
   localparam int CRED_W         = $clog2(NUM_VC + 1),
   localparam int CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   input  logic [ROUTER_ID_BITS-1:0]  req_dest,
   input  logic [PAYLOAD_W-1:0]       req_payload,
   output logic                       req_ready,
   input  logic                       credit_return,
   output logic [FLIT_DATA_WIDTH-1:0] inj_data,
   output logic                       inj_valid,
   output logic [CRED_W-1:0]          credits,
   output logic [7:0]                 drop_cnt,
   output logic                       credit_err
);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [FLIT_DATA_WIDTH-1:0] req_flit;
   logic [FLIT_DATA_WIDTH-1:0] head_flit;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [CNT_W-1:0]           fifo_count;
   logic                       accept;
   logic                       self_dest;
   logic                       push;
   logic                       inject;
   logic                       credits_full;

   always_comb begin
      req_flit = '0;
      req_flit[DEST_MSB -: ROUTER_ID_BITS] = req_dest;
      req_flit[PAYLOAD_W-1:0]              = req_payload;
   end

   // Readiness looks only at the registered full flag, so a same-cycle pop never
   // opens a full queue; holding reset low also closes the request port.
   assign req_ready = reset && !fifo_full;
   assign accept    = req_valid && req_ready;
   assign self_dest = (req_dest == ROUTER_ID_BITS'(ROUTER_ID));
   assign push      = accept && !self_dest;

   assign credits_full = (credits == CRED_W'(NUM_VC));
   assign inject       = !fifo_empty && (credits != '0);

   sync_fifo #(
      .DATAW (FLIT_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (inject),
      .wdata (req_flit),
      .rdata (head_flit),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Output stage: the popped head is registered toward the router.
   always_ff @(posedge clk) begin
      if (!reset) begin
         inj_valid <= 1'b0;
         inj_data  <= '0;
      end else begin
         inj_valid <= inject;
         if (inject) inj_data <= head_flit;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         credits    <= CRED_W'(NUM_VC);
         credit_err <= 1'b0;
      end else begin
         case ({inject, credit_return})
            2'b10: credits <= credits - CRED_W'(1);
            2'b01: begin
               if (credits_full) credit_err <= 1'b1;
               else              credits    <= credits + CRED_W'(1);
            end
            default: credits <= credits;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)                drop_cnt <= 8'd0;
      else if (accept && self_dest) drop_cnt <= sat_inc8(drop_cnt);
   end

   assert property (@(posedge clk) disable iff (!reset)
      fifo_empty == (fifo_count == '0));

endmodule

// File: doc/ni_injector.md
NI_INJECTOR -- requirements
Module: ni_injector

Interface
REQ-001 SHALL have parameter NUM_VC, default 4: local-port VC count at the attached router, which is also the initial credit count.
REQ-002 SHALL have parameter NUM_ROUTERS, default 16: mesh size.
REQ-003 SHALL have parameter ROUTER_ID, default 0: ID of the attached router.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: pending-flit queue depth, power of 2, at least 2.
REQ-005 SHALL have derived parameters ROUTER_ID_BITS = $clog2(NUM_ROUTERS) and PAYLOAD_W = FLIT_DATA_WIDTH - ROUTER_ID_BITS.
REQ-006 SHALL have port clk  in  1  the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset  in  1  reset, synchronous and active-low.
REQ-008 SHALL have port req_valid  in  1  a core presents a flit request.
REQ-009 SHALL have port req_dest  in  ROUTER_ID_BITS  destination router ID.
REQ-010 SHALL have port req_payload  in  PAYLOAD_W  flit payload.
REQ-011 SHALL have port req_ready  out  1  the injector can accept a request this cycle.
REQ-012 SHALL have port credit_return  in  1  one-cycle pulse from the router when a local-port input VC frees.
REQ-013 SHALL have port inj_data  out  FLIT_DATA_WIDTH  flit to the router local input_data.
REQ-014 SHALL have port inj_valid  out  1  flit to the router local input_valid.
REQ-015 SHALL have port credits  out  $clog2(NUM_VC+1)  current credit count.
REQ-016 SHALL have port drop_cnt  out  8  count of self-addressed requests dropped.
REQ-017 SHALL have port credit_err  out  1  sticky flag: a credit was returned while the count was already full.

Function
REQ-018 SHALL accept a request on any rising edge where req_valid and req_ready are both 1.
REQ-019 SHALL drive req_ready = 1 exactly when the FIFO is not full; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-020 SHALL build each accepted flit as {req_dest, req_payload}, with the destination in the MSBs [FLIT_DATA_WIDTH-1 -: ROUTER_ID_BITS].
REQ-021 SHALL drop an accepted request with req_dest == ROUTER_ID: not enqueued, drop_cnt +1, drop_cnt saturates at 255.
REQ-022 SHALL inject when the FIFO is non-empty and credits > 0: pop the head, register it into inj_data, set inj_valid = 1 for exactly one cycle, and decrement credits.
REQ-023 SHALL inject at most one flit per cycle; inj_valid SHALL be 0 in any cycle with no injection, and inj_data SHALL hold its last value.
REQ-024 SHALL meet latency: a flit accepted at edge E0 into an empty FIFO with credits > 0 appears with inj_valid = 1 after edge E1.
REQ-025 SHALL keep credits unchanged when credit_return and an injection occur on the same edge.
REQ-026 SHALL, on credit_return with credits == NUM_VC, hold credits at NUM_VC and set credit_err, which stays set until reset.
REQ-027 SHALL, at credits == 0, hold the FIFO head with no injection until a credit returns; an injection SHALL be possible on the edge after that return.
REQ-028 SHALL, with simultaneous push and pop on a non-full, non-empty FIFO, keep the occupancy unchanged and preserve FIFO order.
REQ-029 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; the full and empty states SHALL be distinguished by a count or an extra pointer bit.

Reset
REQ-030 SHALL, while reset == 0 at a rising edge, empty the FIFO and set credits = NUM_VC, inj_valid = 0, inj_data = 0, drop_cnt = 0, credit_err = 0.
REQ-031 SHALL drive req_ready = 0 during reset and 1 on the first cycle after reset deasserts.
REQ-032 SHALL, on reset asserted mid-operation, discard queued flits and any in-flight inj_valid on the next edge, without emitting a partial or stale flit.

Structure
REQ-033 SHALL take FLIT_DATA_WIDTH, the flit dest-field position, and a ROUTER_ID_BITS helper function from the shared package noc_pkg.
REQ-034 SHALL implement the queue as sub-module sync_fifo (parameters DATAW and DEPTH; push/pop/full/empty/count), reusable by the ejection side.
REQ-035 SHALL keep the credit counter and the inject decision in ni_injector.

Verification
REQ-036 SHALL verify: after reset, a single request with dest = 5 and payload = 0x1 -> inj_valid is high for 1 cycle after E1, with inj_data = {5, 0x1}, and credits = 3.
REQ-037 SHALL verify: 6 back-to-back requests with no credit_return and FIFO_DEPTH = 4 -> 4 injections, the remaining flits stall, req_ready = 0 when full, and credits = 0.
REQ-038 SHALL verify: from credits = 0, one credit_return pulse -> exactly one further injection, in order, and credits returns to 0.
REQ-039 SHALL verify: credit_return and an injection on the same edge -> credits unchanged; credit_return at credits = 4 -> credits = 4 and credit_err = 1.
REQ-040 SHALL verify: a request with dest == ROUTER_ID -> no inj_valid and drop_cnt = 1; 300 such requests -> drop_cnt = 255.
REQ-041 SHALL verify: reset low with 3 flits queued -> no inj_valid afterwards, credits = 4, and req_ready = 1 one cycle after release.
